// File: rtl/fwd_select_ctrl.sv
// Operand-forwarding select generator and load-use hazard detector.
// Tracks rd/regwrite/memread down ID/EX, EX/MEM, MEM/WB and registers EX mux selects.
module fwd_select_ctrl #(
    parameter int REG_W = 5,
    parameter int SEL_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    output logic [SEL_W-1:0] fwd_a_o,
    output logic [SEL_W-1:0] fwd_b_o,
    output logic             hazard_stall_o,
    output logic [REG_W-1:0] ex_rd_o
);

    localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_EXM = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_RSV = SEL_W'(3);

    logic [REG_W-1:0] idex_rd_q, idex_rd_d;
    logic             idex_rw_q, idex_rw_d;
    logic             idex_mr_q, idex_mr_d;
    logic [REG_W-1:0] exmem_rd_q, exmem_rd_d;
    logic             exmem_rw_q, exmem_rw_d;
    logic             exmem_mr_q, exmem_mr_d;
    logic [REG_W-1:0] memwb_rd_q, memwb_rd_d;
    logic             memwb_rw_q, memwb_rw_d;
    logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0] fwd_b_q, fwd_b_d;

    logic             hazard;
    logic [SEL_W-1:0] sel_a_nxt;
    logic [SEL_W-1:0] sel_b_nxt;

    // Stages are compared as they will look after the edge: ID/EX moves to EX/MEM.
    function automatic logic [SEL_W-1:0] next_sel(
        input logic             use_rs,
        input logic [REG_W-1:0] rs,
        input logic             idex_rw,
        input logic [REG_W-1:0] idex_rd,
        input logic             exmem_rw,
        input logic [REG_W-1:0] exmem_rd
    );
        logic live;
        live = use_rs && (rs != '0);
        if (live && idex_rw && (idex_rd == rs)) begin
            return SEL_EXM;
        end else if (live && exmem_rw && (exmem_rd == rs)) begin
            return SEL_WB;
        end else begin
            return SEL_RF;
        end
    endfunction

    always_comb begin
        hazard = idex_mr_q && (idex_rd_q != '0) &&
                 ((id_use_rs1_i && (id_rs1_i == idex_rd_q)) ||
                  (id_use_rs2_i && (id_rs2_i == idex_rd_q)));
    end

    always_comb begin
        sel_a_nxt = next_sel(id_use_rs1_i, id_rs1_i, idex_rw_q,
                             idex_rd_q, exmem_rw_q, exmem_rd_q);
        sel_b_nxt = next_sel(id_use_rs2_i, id_rs2_i, idex_rw_q,
                             idex_rd_q, exmem_rw_q, exmem_rd_q);
    end

    always_comb begin
        idex_rd_d  = idex_rd_q;
        idex_rw_d  = idex_rw_q;
        idex_mr_d  = idex_mr_q;
        exmem_rd_d = exmem_rd_q;
        exmem_rw_d = exmem_rw_q;
        exmem_mr_d = exmem_mr_q;
        memwb_rd_d = memwb_rd_q;
        memwb_rw_d = memwb_rw_q;
        fwd_a_d    = fwd_a_q;
        fwd_b_d    = fwd_b_q;
        if (!stall_i) begin
            exmem_rd_d = idex_rd_q;
            exmem_rw_d = idex_rw_q;
            exmem_mr_d = idex_mr_q;
            memwb_rd_d = exmem_rd_q;
            memwb_rw_d = exmem_rw_q;
            if (flush_i || hazard) begin
                idex_rd_d = '0;
                idex_rw_d = 1'b0;
                idex_mr_d = 1'b0;
                fwd_a_d   = SEL_RF;
                fwd_b_d   = SEL_RF;
            end else begin
                idex_rd_d = id_rd_i;
                idex_rw_d = id_regwrite_i;
                idex_mr_d = id_memread_i;
                fwd_a_d   = sel_a_nxt;
                fwd_b_d   = sel_b_nxt;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_rd_q  <= '0;
            idex_rw_q  <= 1'b0;
            idex_mr_q  <= 1'b0;
            exmem_rd_q <= '0;
            exmem_rw_q <= 1'b0;
            exmem_mr_q <= 1'b0;
            memwb_rd_q <= '0;
            memwb_rw_q <= 1'b0;
            fwd_a_q    <= SEL_RF;
            fwd_b_q    <= SEL_RF;
        end else begin
            idex_rd_q  <= idex_rd_d;
            idex_rw_q  <= idex_rw_d;
            idex_mr_q  <= idex_mr_d;
            exmem_rd_q <= exmem_rd_d;
            exmem_rw_q <= exmem_rw_d;
            exmem_mr_q <= exmem_mr_d;
            memwb_rd_q <= memwb_rd_d;
            memwb_rw_q <= memwb_rw_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
        end
    end

    assign fwd_a_o        = fwd_a_q;
    assign fwd_b_o        = fwd_b_q;
    assign hazard_stall_o = hazard;
    assign ex_rd_o        = idex_rd_q;

    // A select in EX must point at a live, non-load producer in the named stage.
    a_exm_src: assert property (@(posedge clk_i) disable iff (rst_i)
        ((fwd_a_q == SEL_EXM) || (fwd_b_q == SEL_EXM)) |->
            (exmem_rw_q && !exmem_mr_q && (exmem_rd_q != '0)));

    a_wb_src: assert property (@(posedge clk_i) disable iff (rst_i)
        ((fwd_a_q == SEL_WB) || (fwd_b_q == SEL_WB)) |->
            (memwb_rw_q && (memwb_rd_q != '0)));

    a_no_rsv: assert property (@(posedge clk_i) disable iff (rst_i)
        (fwd_a_q != SEL_RSV) && (fwd_b_q != SEL_RSV));

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed-vector bench for fwd_select_ctrl.
// Each task drives one scenario and checks outputs against hand-derived values.
module tb_fwd_select_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       stall_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [4:0] id_rs1_i = '0;
    logic [4:0] id_rs2_i = '0;
    logic       id_use_rs1_i = 1'b0;
    logic       id_use_rs2_i = 1'b0;
    logic [4:0] id_rd_i = '0;
    logic       id_regwrite_i = 1'b0;
    logic       id_memread_i = 1'b0;
    logic [1:0] fwd_a_o;
    logic [1:0] fwd_b_o;
    logic       hazard_stall_o;
    logic [4:0] ex_rd_o;

    int checks = 0;
    int errors = 0;

    fwd_select_ctrl #(.REG_W(5), .SEL_W(2)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .stall_i(stall_i),
        .flush_i(flush_i),
        .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i),
        .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i),
        .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i),
        .fwd_a_o(fwd_a_o),
        .fwd_b_o(fwd_b_o),
        .hazard_stall_o(hazard_stall_o),
        .ex_rd_o(ex_rd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2,
                            input logic [4:0] rd, input logic rw,
                            input logic mr);
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_use_rs1_i  = u1;
        id_use_rs2_i  = u2;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i   = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        drive_id(0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(5, 0, 1, 0, 8, 1, 0);
        tick();
        checks++;
        if (fwd_a_o !== 2'b10) begin
            errors++;
            $display("FAIL rst_pre_fwd_a got %b exp 10", fwd_a_o);
        end
        drive_id(0, 0, 0, 0, 9, 1, 1);
        tick();
        drive_id(9, 0, 1, 0, 4, 1, 0);
        #1;
        checks++;
        if (hazard_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_hazard got %b exp 1", hazard_stall_o);
        end
        // Assert reset mid-cycle; outputs must clear without a clock edge.
        #1;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({fwd_a_o, fwd_b_o, ex_rd_o, hazard_stall_o} !== 10'b0) begin
            errors++;
            $display("FAIL rst_async got a=%b b=%b rd=%0d hz=%b exp all 0",
                     fwd_a_o, fwd_b_o, ex_rd_o, hazard_stall_o);
        end
        drive_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        tick();
        checks++;
        if ({fwd_a_o, fwd_b_o, ex_rd_o} !== 9'b0) begin
            errors++;
            $display("FAIL rst_idle got a=%b b=%b rd=%0d exp 0",
                     fwd_a_o, fwd_b_o, ex_rd_o);
        end
    endtask

    task automatic test_ex_fwd();
        do_reset();
        drive_id(0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(5, 6, 1, 1, 10, 1, 0);
        tick();
        checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b1000) begin
            errors++;
            $display("FAIL ex_fwd got a=%b b=%b exp a=10 b=00", fwd_a_o, fwd_b_o);
        end
        checks++;
        if (ex_rd_o !== 5'd10) begin
            errors++;
            $display("FAIL ex_fwd_rd got %0d exp 10", ex_rd_o);
        end
    endtask

    task automatic test_mem_fwd();
        do_reset();
        drive_id(0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive_id(5, 0, 1, 0, 12, 1, 0);
        tick();
        checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0100) begin
            errors++;
            $display("FAIL mem_fwd got a=%b b=%b exp a=01 b=00", fwd_a_o, fwd_b_o);
        end
        // Two producers of x5: the nearer one must win.
        do_reset();
        drive_id(0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(0, 5, 0, 1, 13, 1, 0);
        tick();
        checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0010) begin
            errors++;
            $display("FAIL fwd_priority got a=%b b=%b exp a=00 b=10", fwd_a_o, fwd_b_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(0, 0, 0, 0, 7, 1, 1);
        tick();
        drive_id(0, 7, 0, 1, 11, 1, 0);
        #1;
        checks++;
        if (hazard_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL lu_hazard got %b exp 1", hazard_stall_o);
        end
        tick();
        checks++;
        if ({ex_rd_o, hazard_stall_o, fwd_b_o} !== 8'b0) begin
            errors++;
            $display("FAIL lu_bubble got rd=%0d hz=%b b=%b exp 0 0 00",
                     ex_rd_o, hazard_stall_o, fwd_b_o);
        end
        tick();
        checks++;
        if ({fwd_b_o, ex_rd_o} !== {2'b01, 5'd11}) begin
            errors++;
            $display("FAIL lu_resume got b=%b rd=%0d exp b=01 rd=11", fwd_b_o, ex_rd_o);
        end
    endtask

    task automatic test_x0_unused();
        do_reset();
        drive_id(0, 0, 0, 0, 0, 1, 0);
        tick();
        drive_id(0, 0, 1, 1, 6, 1, 0);
        #1;
        checks++;
        if (hazard_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_hazard got %b exp 0", hazard_stall_o);
        end
        tick();
        checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0000) begin
            errors++;
            $display("FAIL x0_fwd got a=%b b=%b exp 00 00", fwd_a_o, fwd_b_o);
        end
        do_reset();
        drive_id(0, 0, 0, 0, 3, 1, 1);
        tick();
        drive_id(0, 3, 0, 0, 14, 1, 0);
        #1;
        checks++;
        if (hazard_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL unused_hazard got %b exp 0", hazard_stall_o);
        end
        tick();
        checks++;
        if ({fwd_b_o, ex_rd_o} !== {2'b00, 5'd14}) begin
            errors++;
            $display("FAIL unused_fwd got b=%b rd=%0d exp b=00 rd=14", fwd_b_o, ex_rd_o);
        end
    endtask

    task automatic test_stall();
        // Unstalled reference gives a=01 b=10 rd=7 for the consumer.
        do_reset();
        drive_id(0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(0, 0, 0, 0, 6, 1, 0);
        tick();
        drive_id(5, 6, 1, 1, 7, 1, 0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({fwd_a_o, fwd_b_o, ex_rd_o, hazard_stall_o} !== {4'b0000, 5'd6, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d got a=%b b=%b rd=%0d hz=%b exp 00 00 6 0",
                         i, fwd_a_o, fwd_b_o, ex_rd_o, hazard_stall_o);
            end
        end
        stall_i = 1'b0;
        tick();
        checks++;
        if ({fwd_a_o, fwd_b_o, ex_rd_o} !== {4'b0110, 5'd7}) begin
            errors++;
            $display("FAIL stall_resume got a=%b b=%b rd=%0d exp a=01 b=10 rd=7",
                     fwd_a_o, fwd_b_o, ex_rd_o);
        end
        drive_id(7, 5, 1, 1, 8, 1, 0);
        tick();
        checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b1000) begin
            errors++;
            $display("FAIL stall_next got a=%b b=%b exp a=10 b=00", fwd_a_o, fwd_b_o);
        end
        // Global stall while a load-use hazard is pending.
        do_reset();
        drive_id(0, 0, 0, 0, 7, 1, 1);
        tick();
        drive_id(0, 7, 0, 1, 11, 1, 0);
        stall_i = 1'b1;
        tick();
        checks++;
        if ({hazard_stall_o, ex_rd_o} !== {1'b1, 5'd7}) begin
            errors++;
            $display("FAIL stall_hz got hz=%b rd=%0d exp hz=1 rd=7", hazard_stall_o, ex_rd_o);
        end
        stall_i = 1'b0;
        tick();
        checks++;
        if ({hazard_stall_o, ex_rd_o} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL stall_hz_bubble got hz=%b rd=%0d exp hz=0 rd=0",
                     hazard_stall_o, ex_rd_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive_id(0, 0, 0, 0, 7, 1, 1);
        tick();
        drive_id(7, 0, 1, 0, 12, 1, 0);
        flush_i = 1'b1;
        #1;
        checks++;
        if (hazard_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_hz got %b exp 1", hazard_stall_o);
        end
        tick();
        flush_i = 1'b0;
        #1;
        checks++;
        if ({ex_rd_o, hazard_stall_o} !== 6'b0) begin
            errors++;
            $display("FAIL flush_hz_bubble got rd=%0d hz=%b exp 0 0", ex_rd_o, hazard_stall_o);
        end
        tick();
        checks++;
        if ({fwd_a_o, ex_rd_o} !== {2'b01, 5'd12}) begin
            errors++;
            $display("FAIL flush_hz_once got a=%b rd=%0d exp a=01 rd=12", fwd_a_o, ex_rd_o);
        end
        // Flushed instruction (rd=9) must never be forwarded from.
        do_reset();
        drive_id(0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(5, 0, 1, 0, 9, 1, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if ({fwd_a_o, ex_rd_o} !== 7'b0) begin
            errors++;
            $display("FAIL flush_bubble got a=%b rd=%0d exp 00 0", fwd_a_o, ex_rd_o);
        end
        drive_id(5, 9, 1, 1, 4, 1, 0);
        tick();
        checks++;
        if ({fwd_a_o, fwd_b_o} !== 4'b0100) begin
            errors++;
            $display("FAIL flush_after got a=%b b=%b exp a=01 b=00", fwd_a_o, fwd_b_o);
        end
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_mem_fwd();
        test_load_use();
        test_x0_unused();
        test_stall();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_select_ctrl.md
Name: fwd_select_ctrl

Overview:
- Generates the registered 2-bit select codes that drive the two EX-stage operand 4-way muxes (operand A for rs1, operand B for rs2).
- Tracks the destination register, RegWrite and MemRead of the instructions in ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.
- Sits beside the ID/EX pipeline register. It is the control-side counterpart of the operand muxes: it decides which source each mux passes.

Parameters:
REG_W, 5, register index width
SEL_W, 2, mux select width (fixed encoding below)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous reset, active-high
stall_i  input  1  global freeze (data-cache miss); all internal state and outputs hold
flush_i  input  1  branch taken in ID; ID-stage instruction becomes bubble in ID/EX
id_rs1_i  input  REG_W  rs1 of instruction in ID
id_rs2_i  input  REG_W  rs2 of instruction in ID
id_use_rs1_i  input  1  instruction in ID reads rs1
id_use_rs2_i  input  1  instruction in ID reads rs2
id_rd_i  input  REG_W  rd of instruction in ID
id_regwrite_i  input  1  instruction in ID writes rd
id_memread_i  input  1  instruction in ID is a load
fwd_a_o  output  SEL_W  registered select for operand-A mux in EX
fwd_b_o  output  SEL_W  registered select for operand-B mux in EX
hazard_stall_o  output  1  combinational; freeze PC and IF/ID, bubble ID/EX
ex_rd_o  output  REG_W  rd held in ID/EX, for debug and trace

Behaviour:
- Select encoding:
  - 00 = register-file value from ID/EX
  - 01 = MEM/WB write-back data
  - 10 = EX/MEM ALU result
  - 11 is reserved and never driven
- Internal registers:
  - ID/EX: rd, regwrite, memread
  - EX/MEM: rd, regwrite, memread
  - MEM/WB: rd, regwrite
  - Output registers: fwd_a_o, fwd_b_o
- Reset (async, rst_i=1):
  - All registers cleared to 0.
  - fwd_a_o = fwd_b_o = 00, ex_rd_o = 0.
  - hazard_stall_o evaluates to 0 because ID/EX memread = 0.
  - Reset asserted mid-operation discards all tracked instructions immediately, without waiting for a clock edge.
- Load-use hazard:
  - hazard_stall_o = ID/EX.memread & ID/EX.rd≠0 & ((id_use_rs1_i & id_rs1_i==ID/EX.rd) | (id_use_rs2_i & id_rs2_i==ID/EX.rd)).
  - Pure combinational; must not depend on stall_i.
- Per-edge update priority: stall_i > (flush_i | hazard_stall_o) > normal.
  - stall_i=1: every register holds, including the output selects.
  - Bubble: ID/EX loads rd=0, regwrite=0, memread=0. Next fwd_a_o = fwd_b_o = 00. EX/MEM and MEM/WB advance normally.
  - Normal: ID/EX←ID inputs, EX/MEM←ID/EX, MEM/WB←EX/MEM, selects←computed next values.
- Next-select computation (operand A shown; operand B is identical with rs2):
  - Compare against the stages as they will be one cycle later.
  - If id_use_rs1_i & id_rs1_i≠0 & ID/EX.regwrite & ID/EX.rd==id_rs1_i → 10 (that instruction will sit in EX/MEM).
  - Else if id_use_rs1_i & id_rs1_i≠0 & EX/MEM.regwrite & EX/MEM.rd==id_rs1_i → 01 (it will sit in MEM/WB).
  - Else 00.
  - A load currently in ID/EX never yields 10, because the hazard stall bubbles first.
- Write-back→ID bypass is not this block's job: the register file writes first and reads second in the same cycle.
- x0: rd=0 or rs=0 never produces a forward or a stall, even with regwrite=1.
- Latency: selects are valid in the cycle the instruction occupies EX, one edge after it was in ID.
- Simultaneous flush_i and hazard_stall_o: a single bubble. The stall still holds IF/ID externally; the hazard re-evaluates next cycle against the bubble and clears.
- stall_i during hazard: hold everything. hazard_stall_o stays asserted while the inputs are unchanged.

Test Plan:
- Reset: assert rst_i between clock edges → all outputs 0 immediately; after release with idle inputs, fwd_a_o/fwd_b_o stay 00.
- EX hazard: cycle0 ID add x5 (rd=5, regwrite); cycle1 ID sub rs1=5, rs2=6 → in cycle2 fwd_a_o=10, fwd_b_o=00.
- MEM hazard plus priority: add x5; nop; use rs1=5 → fwd_a_o=01. Sequence add x5; add x5; use rs2=5 → fwd_b_o=10, because the nearer producer wins.
- Load-use: lw x7 in ID/EX with ID rs2=7, use_rs2=1 → hazard_stall_o=1 that cycle; next cycle ID/EX.rd=0 and hazard_stall_o=0; the following cycle fwd_b_o=01.
- x0 and unused source: add x0 then use rs1=0 → 00, no stall. lw x3 with ID rs2=3 and use_rs2=0 → no stall.
- stall_i: assert for 3 cycles mid-sequence → fwd_*_o, ex_rd_o and internal stages frozen; on release the sequence resumes with the same select values as the unstalled reference run. flush_i together with a hazard → exactly one bubble.
